// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_GAP
  } i2c_state_e;

  localparam int unsigned I2C_WORD_W        = 24;
  localparam int unsigned I2C_BYTES         = 3;
  localparam int unsigned I2C_BITS_PER_BYTE = 8;

  // SCL phases per state step and per complete word attempt
  localparam int unsigned START_PHASES       = 2;
  localparam int unsigned BIT_PHASES         = 2;
  localparam int unsigned STOP_PHASES        = 2;
  localparam int unsigned GAP_PHASES         = 2;
  localparam int unsigned PHASES_PER_ATTEMPT = START_PHASES
                                             + I2C_BYTES * (I2C_BITS_PER_BYTE + 1) * BIT_PHASES
                                             + STOP_PHASES + GAP_PHASES;
  localparam int unsigned PHASE_IDX_W        = $clog2(PHASES_PER_ATTEMPT);

endpackage

// File: rtl/i2c_phase_timer.sv
// SCL phase timer: counts CLK_DIV cycles per phase, held cleared while not running.
module i2c_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_first,
  output logic o_strobe
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_first  = i_run && (cnt == '0);
  assign o_strobe = i_run && (cnt == LAST);

endmodule

// File: rtl/i2c_config_sequencer.sv
// I2C register-write sequencer: one START / 3 bytes / STOP transaction per ROM word.
// Define I2C_ACK_CHECK_EN to enable ACK checking, NACK retry and error reporting.
module i2c_config_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned N_WORDS   = 7,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned AW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic [AW-1:0]         o_cfg_addr,
  input  logic [I2C_WORD_W-1:0] i_cfg_data,
  input  logic                  i_sdat,
  output logic                  o_sclk,
  output logic                  o_sdat,
  output logic                  o_oen,
  output logic                  o_busy,
  output logic                  o_finished,
  output logic                  o_error,
  output logic [AW-1:0]         o_err_idx
);

  localparam logic [PHASE_IDX_W-1:0] LAST_PHASE = PHASE_IDX_W'(PHASES_PER_ATTEMPT - 1);
  localparam logic [2:0]             LAST_BIT   = 3'(I2C_BITS_PER_BYTE - 1);
  localparam logic [1:0]             LAST_BYTE  = 2'(I2C_BYTES - 1);

  i2c_state_e                 state;
  logic [PHASE_IDX_W-1:0]     phase_idx;
  logic [2:0]                 bit_cnt;
  logic [1:0]                 byte_cnt;
  logic [I2C_WORD_W-1:0]      shreg;
  logic [AW-1:0]              word_idx;
  logic                       done_pending;
  logic                       busy;
  logic                       finished;
  logic                       first;
  logic                       strobe;
  logic                       ph;
  logic                       accept;
  logic                       load;
  logic                       attempt_go;
  logic                       ack_end;
  logic                       stop_end;
  logic                       gap_end;
  logic                       last_word;
  logic                       nack;
  logic                       attempt_ok;
  logic                       give_up;

  i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (state != ST_IDLE),
    .o_first  (first),
    .o_strobe (strobe)
  );

  assign ph         = phase_idx[0];
  assign accept     = (state == ST_IDLE) && i_start;
  assign load       = (state == ST_START) && !ph && first;
  assign attempt_go = (state == ST_START) && strobe && ph;
  assign ack_end    = (state == ST_ACK) && strobe && ph;
  assign stop_end   = (state == ST_STOP) && strobe && ph;
  assign gap_end    = (state == ST_GAP) && strobe && (phase_idx == LAST_PHASE);
  assign last_word  = (word_idx == AW'(N_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      phase_idx    <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      word_idx     <= '0;
      done_pending <= 1'b0;
      busy         <= 1'b0;
      finished     <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (accept) begin
        state        <= ST_START;
        busy         <= 1'b1;
        word_idx     <= '0;
        phase_idx    <= '0;
        done_pending <= 1'b0;
      end
      if (load) shreg <= i_cfg_data;
      if (strobe) begin
        phase_idx <= phase_idx + PHASE_IDX_W'(1);
        case (state)
          ST_START: if (ph) begin
            state    <= ST_BIT;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
          ST_BIT: if (ph) begin
            shreg   <= {shreg[I2C_WORD_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= ST_ACK;
          end
          ST_ACK: if (ph) begin
            if (nack || byte_cnt == LAST_BYTE) begin
              state <= ST_STOP;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              state    <= ST_BIT;
            end
          end
          ST_STOP: if (ph) begin
            state <= ST_GAP;
            if (attempt_ok && !last_word) word_idx <= word_idx + AW'(1);
            if ((attempt_ok && last_word) || give_up) done_pending <= 1'b1;
          end
          // GAP runs to the fixed attempt length, so an aborted attempt still spans 60 phases
          ST_GAP: if (phase_idx == LAST_PHASE) begin
            phase_idx <= '0;
            if (done_pending) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              state <= ST_START;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_ACK_CHECK_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic          failed;
  logic [RW-1:0] retry_cnt;
  logic          error;
  logic [AW-1:0] err_idx;

  assign nack       = i_sdat;
  assign attempt_ok = !failed;
  assign give_up    = failed && (retry_cnt == RW'(MAX_RETRY));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      failed    <= 1'b0;
      retry_cnt <= '0;
      error     <= 1'b0;
      err_idx   <= '0;
    end else begin
      if (accept) begin
        retry_cnt <= '0;
        error     <= 1'b0;
      end
      if (attempt_go) failed <= 1'b0;
      if (ack_end && i_sdat) failed <= 1'b1;
      if (stop_end) begin
        if (!failed) retry_cnt <= '0;
        else if (!give_up) retry_cnt <= retry_cnt + RW'(1);
      end
      if (gap_end && done_pending && failed) begin
        error   <= 1'b1;
        err_idx <= word_idx;
      end
    end
  end

  assign o_error   = error;
  assign o_err_idx = err_idx;
`else
  logic unused_ack;

  assign nack       = 1'b0;
  assign attempt_ok = 1'b1;
  assign give_up    = 1'b0;
  assign unused_ack = i_sdat | ack_end | gap_end | attempt_go | (MAX_RETRY == 0);
  assign o_error    = 1'b0;
  assign o_err_idx  = '0;
`endif

  always_comb begin
    o_sclk = 1'b1;
    o_sdat = 1'b1;
    o_oen  = 1'b1;
    case (state)
      ST_START: o_sdat = ~ph;
      ST_BIT: begin
        o_sclk = ph;
        o_sdat = shreg[I2C_WORD_W-1];
      end
      ST_ACK: begin
        o_sclk = ph;
        o_oen  = 1'b0;
      end
      ST_STOP: begin
        o_sclk = ph;
        o_sdat = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_cfg_addr = word_idx;
  assign o_busy     = busy;
  assign o_finished = finished;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench: bus-level decoder and ACK responder, word/retry reference model.
module tb_i2c_config_sequencer;

`ifdef I2C_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif
  localparam int CD_A      = 2;
  localparam int NW_A      = 2;
  localparam int RETRY_A   = 3;
  localparam int PH_ATTEMPT = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, start_b;
  logic [0:0]  addr_a, addr_b, erridx_a, erridx_b;
  logic [23:0] data_a, data_b;
  logic        sdin_a, sdin_b;
  logic        sclk_a, sdat_a, oen_a, busy_a, fin_a, err_a;
  logic        sclk_b, sdat_b, oen_b, busy_b, fin_b, err_b;
  logic [23:0] rom_a [0:1];
  logic [2:0]  nack_plan [0:63];

  assign data_a = rom_a[addr_a];
  assign data_b = 24'hA5_5A_C3;
  assign sdin_b = 1'b0;

  i2c_config_sequencer #(.N_WORDS(NW_A), .CLK_DIV(CD_A), .MAX_RETRY(RETRY_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_cfg_addr(addr_a),
    .i_cfg_data(data_a), .i_sdat(sdin_a), .o_sclk(sclk_a), .o_sdat(sdat_a),
    .o_oen(oen_a), .o_busy(busy_a), .o_finished(fin_a), .o_error(err_a),
    .o_err_idx(erridx_a)
  );

  i2c_config_sequencer #(.N_WORDS(1), .CLK_DIV(1), .MAX_RETRY(RETRY_A)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_cfg_addr(addr_b),
    .i_cfg_data(data_b), .i_sdat(sdin_b), .o_sclk(sclk_b), .o_sdat(sdat_b),
    .o_oen(oen_b), .o_busy(busy_b), .o_finished(fin_b), .o_error(err_b),
    .o_err_idx(erridx_b)
  );

  // Bus decoder for dut_a: START/STOP framing, data bits at SCL rise
  typedef struct { logic [31:0] bits; int nbits; int addr; } txn_t;
  txn_t cap[$];
  txn_t cur;
  int   txn_no = 0, byte_no = 0;
  logic p_scl = 1'b1, p_sda = 1'b1, p_oen = 1'b1, p_busy = 1'b0;

  always @(negedge clk) begin
    if (busy_a && !p_busy) begin
      cap.delete();
      txn_no  = 0;
      byte_no = 0;
    end
    if (p_scl && sclk_a && p_sda && !sdat_a && oen_a && p_oen) begin
      txn_no    = txn_no + 1;
      byte_no   = 0;
      cur.bits  = '0;
      cur.nbits = 0;
      cur.addr  = int'(addr_a);
    end else if (p_scl && sclk_a && !p_sda && sdat_a && oen_a && p_oen) begin
      // the SCL rise just before a STOP carries no data bit
      cur.bits  = cur.bits >> 1;
      cur.nbits = cur.nbits - 1;
      cap.push_back(cur);
    end else if (!p_scl && sclk_a && oen_a) begin
      cur.bits  = {cur.bits[30:0], sdat_a};
      cur.nbits = cur.nbits + 1;
    end
    if (p_oen && !oen_a) byte_no = byte_no + 1;
    p_scl  = sclk_a;
    p_sda  = sdat_a;
    p_oen  = oen_a;
    p_busy = busy_a;
  end

  always_comb begin
    sdin_a = 1'b0;
    if (!oen_a && txn_no >= 1 && txn_no <= 63 && byte_no >= 1 && byte_no <= 3)
      sdin_a = nack_plan[txn_no][byte_no-1];
  end

  // Reference model: expected transactions, attempt count and error outcome
  typedef struct { logic [23:0] word; int nbytes; int addr; } exp_t;
  exp_t exp_q[$];
  int   exp_attempts, exp_err_idx;
  bit   exp_err;

  task automatic model(input int nw, input int max_retry);
    int   tries;
    bit   ok, failed;
    int   nb;
    exp_t e;
    exp_q.delete();
    exp_attempts = 0;
    exp_err      = 1'b0;
    exp_err_idx  = 0;
    for (int w = 0; w < nw && !exp_err; w++) begin
      tries = 0;
      ok    = 1'b0;
      while (!ok && !exp_err) begin
        exp_attempts++;
        failed = ACK_CHECK && (nack_plan[exp_attempts] != 3'b000);
        nb = 3;
        if (failed)
          for (int b = 2; b >= 0; b--) if (nack_plan[exp_attempts][b]) nb = b + 1;
        e.word = rom_a[w]; e.nbytes = nb; e.addr = w;
        exp_q.push_back(e);
        if (!failed) ok = 1'b1;
        else if (tries < max_retry) tries++;
        else begin exp_err = 1'b1; exp_err_idx = w; end
      end
    end
  endtask

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) nack_plan[i] = 3'b000;
  endtask

  task automatic run_a(input string tag, input int inj);
    int   cyc, busy_gap;
    bit   done;
    logic [31:0] ew;
    model(NW_A, RETRY_A);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk({tag, ".busy_rise"}, busy_a, 1);
    chk({tag, ".err_clr"}, err_a, 0);
    cyc = 0; done = 1'b0; busy_gap = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == inj);
      if (fin_a) done = 1'b1;
      else if (!busy_a) busy_gap++;
    end
    start_a = 1'b0;
    chk({tag, ".finish_cycles"}, cyc, exp_attempts * PH_ATTEMPT * CD_A);
    chk({tag, ".busy_hold"}, busy_gap, 0);
    chk({tag, ".busy_fall"}, busy_a, 0);
    chk({tag, ".error"}, err_a, exp_err);
    if (exp_err) chk({tag, ".err_idx"}, erridx_a, exp_err_idx);
    chk({tag, ".txn_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      ew = {8'h00, exp_q[i].word} >> (24 - 8 * exp_q[i].nbytes);
      chk($sformatf("%s.txn%0d.addr", tag, i), cap[i].addr, exp_q[i].addr);
      chk($sformatf("%s.txn%0d.nbits", tag, i), cap[i].nbits, 8 * exp_q[i].nbytes);
      chk($sformatf("%s.txn%0d.bits", tag, i), cap[i].bits, ew);
    end
    @(negedge clk);
    chk({tag, ".fin_pulse"}, fin_a, 0);
  endtask

  initial begin
    int cyc, tog_bad;
    bit done;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rom_a[0] = 24'h34_1E_00;
    rom_a[1] = 24'h34_08_19;
    clear_plan();
    repeat (3) @(negedge clk);
    chk("rst.sclk", sclk_a, 1);
    chk("rst.sdat", sdat_a, 1);
    chk("rst.oen", oen_a, 1);
    chk("rst.busy", busy_a, 0);
    chk("rst.fin", fin_a, 0);
    chk("rst.err", err_a, 0);
    chk("rst.erridx", erridx_a, 0);
    chk("rst.addr", addr_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_a("t1_ack", -1);
    nack_plan[2] = 3'b010;
    run_a("t2_retry", -1);
    for (int i = 0; i < 64; i++) nack_plan[i] = 3'b111;
    run_a("t3_perm_nack", -1);
    clear_plan();
    run_a("t4_busy_start", 100);

    // Reset while dut_a is in BIT of word 1 (SCL low phase)
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (128) @(negedge clk);
    chk("rstmid.in_bit_scl_low", sclk_a, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid.sclk", sclk_a, 1);
    chk("rstmid.sdat", sdat_a, 1);
    chk("rstmid.oen", oen_a, 1);
    chk("rstmid.busy", busy_a, 0);
    chk("rstmid.addr", addr_a, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid.idle_busy", busy_a, 0);
    chk("rstmid.idle_sclk", sclk_a, 1);

    for (int r = 0; r < 4; r++) begin
      rom_a[0] = 24'($urandom);
      rom_a[1] = 24'($urandom);
      for (int i = 0; i < 64; i++)
        nack_plan[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      run_a($sformatf("rnd%0d", r), -1);
    end

    // dut_b: CLK_DIV=1, single word, one-cycle SCL phases
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    chk("b.busy_rise", busy_b, 1);
    cyc = 0; done = 1'b0; tog_bad = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (fin_b) done = 1'b1;
      else if (cyc >= 2 && cyc <= 55 && sclk_b !== cyc[0]) tog_bad++;
    end
    chk("b.finish_cycles", cyc, PH_ATTEMPT);
    chk("b.scl_toggle", tog_bad, 0);
    chk("b.busy_fall", busy_b, 0);
    chk("b.error", err_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
